// File: rtl/ipic_cmd_engine.sv
// ipic_cmd_engine: parses framed command packets from the TX FIFO and issues
// single-beat IPIC master reads/writes, with a read response stream, a
// per-transaction timeout and a sticky error status.
// Optional feature macro: RMW_OP_EN (enables opcode 3, read-modify-write).
module ipic_cmd_engine #(
   parameter int unsigned C_DATA_WIDTH     = 32,
   parameter int unsigned C_ADDR_WIDTH     = 32,
   parameter int unsigned C_MAX_BEATS      = 16,
   parameter int unsigned C_CNT_WIDTH      = 8,
   parameter int unsigned C_ADDR_STRIDE    = 4,
   parameter int unsigned C_TIMEOUT_CYCLES = 1024
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      fifo_empty,
   output logic                      fifo_rd_en,
   input  logic [C_DATA_WIDTH-1:0]   fifo_dread,
   input  logic                      fifo_valid,
   output logic                      ip2bus_mstrd_req,
   output logic                      ip2bus_mstwr_req,
   output logic [C_ADDR_WIDTH-1:0]   ip2bus_mst_addr,
   output logic [C_DATA_WIDTH/8-1:0] ip2bus_mst_be,
   output logic [C_DATA_WIDTH-1:0]   ip2bus_mstwr_d,
   input  logic                      bus2ip_mst_cmdack,
   input  logic                      bus2ip_mst_cmplt,
   input  logic                      bus2ip_mst_error,
   input  logic [C_DATA_WIDTH-1:0]   bus2ip_mstrd_d,
   input  logic                      bus2ip_mstrd_src_rdy_n,
   output logic                      resp_valid,
   output logic [C_DATA_WIDTH-1:0]   resp_data,
   input  logic                      resp_ready,
   input  logic                      err_clr,
   output logic                      busy,
   output logic                      cmd_error,
   output logic [2:0]                error_code,
   output logic [C_CNT_WIDTH-1:0]    cmd_count,
   output logic [C_CNT_WIDTH-1:0]    drop_count
);

   localparam int unsigned TMR_W = $clog2(C_TIMEOUT_CYCLES + 1);

   localparam logic [3:0] OP_WR  = 4'd1;
   localparam logic [3:0] OP_RD  = 4'd2;
`ifdef RMW_OP_EN
   localparam logic [3:0] OP_RMW = 4'd3;
`endif

   localparam logic [2:0] ERR_OP  = 3'd1;
   localparam logic [2:0] ERR_N   = 3'd2;
   localparam logic [2:0] ERR_BUS = 3'd3;
   localparam logic [2:0] ERR_TMO = 3'd4;

   typedef enum logic [3:0] {
      S_SYNC,
      S_HDR,
      S_ADDR,
      S_WDATA,
`ifdef RMW_OP_EN
      S_MASK,
      S_VAL,
`endif
      S_ISSUE,
      S_WAIT_ACK,
      S_WAIT_CMPLT,
      S_RESP
   } state_t;

   state_t                   state_q, state_d;
   logic                     pend_q, pend_d;
   logic [C_CNT_WIDTH-1:0]   n_q, n_d;
   logic [C_CNT_WIDTH-1:0]   beat_q, beat_d;
   logic [C_ADDR_WIDTH-1:0]  addr_q, addr_d;
   logic [C_DATA_WIDTH-1:0]  wdata_q, wdata_d;
   logic [C_DATA_WIDTH-1:0]  rdata_q, rdata_d;
   logic                     is_rd_q, is_rd_d;
   logic                     rd_req_q, rd_req_d;
   logic                     wr_req_q, wr_req_d;
   logic [TMR_W-1:0]         tmr_q, tmr_d;
   logic                     resp_valid_q, resp_valid_d;
   logic [C_CNT_WIDTH-1:0]   cmd_count_q, cmd_count_d;
   logic [C_CNT_WIDTH-1:0]   drop_count_q, drop_count_d;
   logic                     cmd_error_q, cmd_error_d;
   logic [2:0]               error_code_q, error_code_d;
`ifdef RMW_OP_EN
   logic [C_DATA_WIDTH-1:0]  mask_q, mask_d;
   logic                     rmw_q, rmw_d;
`endif

   logic                     need_word;
   logic                     consume;
   logic                     err_new;
   logic [2:0]               err_code_new;
   logic                     cmd_done;
   logic [3:0]               hdr_op;
   logic [C_CNT_WIDTH-1:0]   hdr_n;
   logic [C_CNT_WIDTH-1:0]   beat_nx;
   logic [C_DATA_WIDTH-1:0]  rd_cap;

   assign consume          = pend_q & fifo_valid;
   assign busy             = (state_q != S_SYNC);
   assign ip2bus_mstrd_req = rd_req_q;
   assign ip2bus_mstwr_req = wr_req_q;
   assign ip2bus_mst_addr  = addr_q;
   assign ip2bus_mst_be    = '1;
   assign ip2bus_mstwr_d   = wdata_q;
   assign resp_valid       = resp_valid_q;
   assign resp_data        = rdata_q;
   assign cmd_error        = cmd_error_q;
   assign error_code       = error_code_q;
   assign cmd_count        = cmd_count_q;
   assign drop_count       = drop_count_q;

   // Next-state: packet parsing, beat sequencing, FIFO pops and status updates
   always_comb begin
      state_d      = state_q;
      n_d          = n_q;
      beat_d       = beat_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      rdata_d      = rdata_q;
      is_rd_d      = is_rd_q;
      rd_req_d     = rd_req_q;
      wr_req_d     = wr_req_q;
      tmr_d        = tmr_q;
      resp_valid_d = resp_valid_q;
      cmd_count_d  = cmd_count_q;
      drop_count_d = drop_count_q;
      cmd_error_d  = cmd_error_q;
      error_code_d = error_code_q;
`ifdef RMW_OP_EN
      mask_d       = mask_q;
      rmw_d        = rmw_q;
`endif
      need_word    = 1'b0;
      err_new      = 1'b0;
      err_code_new = '0;
      cmd_done     = 1'b0;
      hdr_op       = fifo_dread[C_DATA_WIDTH-1 -: 4];
      hdr_n        = fifo_dread[C_CNT_WIDTH-1:0];
      beat_nx      = beat_q + C_CNT_WIDTH'(1);
      rd_cap       = bus2ip_mstrd_src_rdy_n ? rdata_q : bus2ip_mstrd_d;

      case (state_q)
         S_SYNC: begin
            need_word = 1'b1;
            if (consume) begin
               if (fifo_dread == '0) begin
                  state_d = S_HDR;
               end else if (drop_count_q != '1) begin
                  drop_count_d = drop_count_q + C_CNT_WIDTH'(1);
               end
            end
         end
         S_HDR: begin
            need_word = 1'b1;
            if (consume) begin
`ifdef RMW_OP_EN
               rmw_d = 1'b0;
`endif
               if (hdr_op == OP_WR || hdr_op == OP_RD) begin
                  if (hdr_n == '0 || hdr_n > C_CNT_WIDTH'(C_MAX_BEATS)) begin
                     err_new      = 1'b1;
                     err_code_new = ERR_N;
                     state_d      = S_SYNC;
                  end else begin
                     n_d     = hdr_n;
                     is_rd_d = (hdr_op == OP_RD);
                     state_d = S_ADDR;
                  end
`ifdef RMW_OP_EN
               end else if (hdr_op == OP_RMW) begin
                  n_d     = C_CNT_WIDTH'(1);
                  is_rd_d = 1'b1;
                  rmw_d   = 1'b1;
                  state_d = S_ADDR;
`endif
               end else begin
                  err_new      = 1'b1;
                  err_code_new = ERR_OP;
                  state_d      = S_SYNC;
               end
            end
         end
         S_ADDR: begin
            need_word = 1'b1;
            if (consume) begin
               addr_d = C_ADDR_WIDTH'(fifo_dread);
               beat_d = '0;
`ifdef RMW_OP_EN
               if (rmw_q)        state_d = S_MASK;
               else if (is_rd_q) state_d = S_ISSUE;
               else              state_d = S_WDATA;
`else
               state_d = is_rd_q ? S_ISSUE : S_WDATA;
`endif
            end
         end
         S_WDATA: begin
            need_word = 1'b1;
            if (consume) begin
               wdata_d = fifo_dread;
               state_d = S_ISSUE;
            end
         end
`ifdef RMW_OP_EN
         S_MASK: begin
            need_word = 1'b1;
            if (consume) begin
               mask_d  = fifo_dread;
               state_d = S_VAL;
            end
         end
         S_VAL: begin
            need_word = 1'b1;
            if (consume) begin
               wdata_d = fifo_dread;
               state_d = S_ISSUE;
            end
         end
`endif
         S_ISSUE: begin
            rd_req_d = is_rd_q;
            wr_req_d = ~is_rd_q;
            tmr_d    = '0;
            state_d  = S_WAIT_ACK;
         end
         S_WAIT_ACK, S_WAIT_CMPLT: begin
            if (is_rd_q) rdata_d = rd_cap;
            if (bus2ip_mst_cmplt) begin
               rd_req_d = 1'b0;
               wr_req_d = 1'b0;
               if (bus2ip_mst_error) begin
                  err_new      = 1'b1;
                  err_code_new = ERR_BUS;
                  state_d      = S_SYNC;
               end else if (is_rd_q) begin
`ifdef RMW_OP_EN
                  // RMW read leg: merge and re-issue as a write to the same address
                  if (rmw_q) begin
                     wdata_d = (rd_cap & ~mask_q) | (wdata_q & mask_q);
                     is_rd_d = 1'b0;
                     state_d = S_ISSUE;
                  end else begin
                     resp_valid_d = 1'b1;
                     state_d      = S_RESP;
                  end
`else
                  resp_valid_d = 1'b1;
                  state_d      = S_RESP;
`endif
               end else if (beat_nx == n_q) begin
                  cmd_done = 1'b1;
                  state_d  = S_SYNC;
               end else begin
                  beat_d  = beat_nx;
                  addr_d  = addr_q + C_ADDR_WIDTH'(C_ADDR_STRIDE);
                  state_d = S_WDATA;
               end
            end else if (tmr_q == TMR_W'(C_TIMEOUT_CYCLES - 1)) begin
               rd_req_d     = 1'b0;
               wr_req_d     = 1'b0;
               err_new      = 1'b1;
               err_code_new = ERR_TMO;
               state_d      = S_SYNC;
            end else begin
               tmr_d = tmr_q + TMR_W'(1);
               if (bus2ip_mst_cmdack) state_d = S_WAIT_CMPLT;
            end
         end
         S_RESP: begin
            if (resp_ready) begin
               resp_valid_d = 1'b0;
               if (beat_nx == n_q) begin
                  cmd_done = 1'b1;
                  state_d  = S_SYNC;
               end else begin
                  beat_d  = beat_nx;
                  addr_d  = addr_q + C_ADDR_WIDTH'(C_ADDR_STRIDE);
                  state_d = S_ISSUE;
               end
            end
         end
         default: state_d = S_SYNC;
      endcase

      // single outstanding pop: a new one only after the previous word arrived
      fifo_rd_en = need_word & ~pend_q & ~fifo_empty & ~reset;
      pend_d     = fifo_rd_en | (pend_q & ~fifo_valid);

      if (cmd_done) cmd_count_d = cmd_count_q + C_CNT_WIDTH'(1);

      // first error wins; a clear coinciding with a new error keeps the new one
      if (err_clr) begin
         cmd_error_d  = err_new;
         error_code_d = err_new ? err_code_new : 3'd0;
      end else if (err_new && !cmd_error_q) begin
         cmd_error_d  = 1'b1;
         error_code_d = err_code_new;
      end
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_SYNC;
         pend_q       <= 1'b0;
         n_q          <= '0;
         beat_q       <= '0;
         addr_q       <= '0;
         wdata_q      <= '0;
         rdata_q      <= '0;
         is_rd_q      <= 1'b0;
         rd_req_q     <= 1'b0;
         wr_req_q     <= 1'b0;
         tmr_q        <= '0;
         resp_valid_q <= 1'b0;
         cmd_count_q  <= '0;
         drop_count_q <= '0;
         cmd_error_q  <= 1'b0;
         error_code_q <= '0;
`ifdef RMW_OP_EN
         mask_q       <= '0;
         rmw_q        <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         pend_q       <= pend_d;
         n_q          <= n_d;
         beat_q       <= beat_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         rdata_q      <= rdata_d;
         is_rd_q      <= is_rd_d;
         rd_req_q     <= rd_req_d;
         wr_req_q     <= wr_req_d;
         tmr_q        <= tmr_d;
         resp_valid_q <= resp_valid_d;
         cmd_count_q  <= cmd_count_d;
         drop_count_q <= drop_count_d;
         cmd_error_q  <= cmd_error_d;
         error_code_q <= error_code_d;
`ifdef RMW_OP_EN
         mask_q       <= mask_d;
         rmw_q        <= rmw_d;
`endif
      end
   end

endmodule

// File: tb/tb_ipic_cmd_engine.sv
// Scoreboard bench for ipic_cmd_engine: a FIFO model feeds packets, an IPIC
// slave model answers requests, monitors compare requests and responses
// against queues of hand-computed expectations.
module tb_ipic_cmd_engine;

   logic        clk = 1'b0;
   logic        reset;
   logic        fifo_empty;
   logic        fifo_rd_en;
   logic [31:0] fifo_dread;
   logic        fifo_valid;
   logic        ip2bus_mstrd_req;
   logic        ip2bus_mstwr_req;
   logic [31:0] ip2bus_mst_addr;
   logic [3:0]  ip2bus_mst_be;
   logic [31:0] ip2bus_mstwr_d;
   logic        bus2ip_mst_cmdack;
   logic        bus2ip_mst_cmplt;
   logic        bus2ip_mst_error;
   logic [31:0] bus2ip_mstrd_d;
   logic        bus2ip_mstrd_src_rdy_n;
   logic        resp_valid;
   logic [31:0] resp_data;
   logic        resp_ready;
   logic        err_clr;
   logic        busy;
   logic        cmd_error;
   logic [2:0]  error_code;
   logic [7:0]  cmd_count;
   logic [7:0]  drop_count;

   always #5 clk = ~clk;

   ipic_cmd_engine #(
      .C_DATA_WIDTH     (32),
      .C_ADDR_WIDTH     (32),
      .C_MAX_BEATS      (16),
      .C_CNT_WIDTH      (8),
      .C_ADDR_STRIDE    (4),
      .C_TIMEOUT_CYCLES (16)
   ) dut (
      .clk                    (clk),
      .reset                  (reset),
      .fifo_empty             (fifo_empty),
      .fifo_rd_en             (fifo_rd_en),
      .fifo_dread             (fifo_dread),
      .fifo_valid             (fifo_valid),
      .ip2bus_mstrd_req       (ip2bus_mstrd_req),
      .ip2bus_mstwr_req       (ip2bus_mstwr_req),
      .ip2bus_mst_addr        (ip2bus_mst_addr),
      .ip2bus_mst_be          (ip2bus_mst_be),
      .ip2bus_mstwr_d         (ip2bus_mstwr_d),
      .bus2ip_mst_cmdack      (bus2ip_mst_cmdack),
      .bus2ip_mst_cmplt       (bus2ip_mst_cmplt),
      .bus2ip_mst_error       (bus2ip_mst_error),
      .bus2ip_mstrd_d         (bus2ip_mstrd_d),
      .bus2ip_mstrd_src_rdy_n (bus2ip_mstrd_src_rdy_n),
      .resp_valid             (resp_valid),
      .resp_data              (resp_data),
      .resp_ready             (resp_ready),
      .err_clr                (err_clr),
      .busy                   (busy),
      .cmd_error              (cmd_error),
      .error_code             (error_code),
      .cmd_count              (cmd_count),
      .drop_count             (drop_count)
   );

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   logic [31:0] fifo_q[$];
   wr_t         exp_wr[$];
   logic [31:0] exp_rd[$];
   logic [31:0] exp_resp[$];
   logic [31:0] slv_rdata[$];

   int n_cmp = 0;
   int n_bad = 0;

   bit slv_silent   = 1'b0;
   bit slv_err_next = 1'b0;
   int slv_lat      = 0;
   bit seen         = 1'b0;
   int hi_cnt       = 0;
   int resp_seen    = 0;
   int stall_at     = -1;
   int stall_left   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   task automatic fail_now(input string nm);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: event occurred that no expectation allowed", nm);
   endtask

   task automatic push(input logic [31:0] w);
      fifo_q.push_back(w);
   endtask

   // FIFO model: one-cycle read latency behind fifo_rd_en
   initial begin : fifo_model
      bit          nxt;
      logic [31:0] w;
      fifo_valid = 1'b0;
      fifo_dread = '0;
      fifo_empty = 1'b1;
      w          = '0;
      forever begin
         @(negedge clk);
         nxt = fifo_rd_en && (fifo_q.size() != 0) && !reset;
         if (nxt) w = fifo_q.pop_front();
         @(posedge clk);
         #1;
         fifo_valid = nxt;
         fifo_dread = nxt ? w : 32'h0;
         fifo_empty = (fifo_q.size() == 0);
      end
   end

   // IPIC slave model and request monitor
   initial begin : slave
      wr_t         w;
      logic [31:0] a;
      logic [31:0] rd;
      bit          is_rd;
      bus2ip_mst_cmdack      = 1'b0;
      bus2ip_mst_cmplt       = 1'b0;
      bus2ip_mst_error       = 1'b0;
      bus2ip_mstrd_d         = '0;
      bus2ip_mstrd_src_rdy_n = 1'b1;
      forever begin
         @(negedge clk);
         if (reset || !(ip2bus_mstrd_req || ip2bus_mstwr_req)) begin
            seen = 1'b0;
            continue;
         end
         if (seen) begin
            hi_cnt++;
            continue;
         end
         seen   = 1'b1;
         hi_cnt = 1;
         is_rd  = ip2bus_mstrd_req;
         rd     = 32'hDEAD_BEEF;
         chk("be", 32'(ip2bus_mst_be), 32'hF);
         if (is_rd) begin
            if (exp_rd.size() == 0) fail_now("unexpected_rd_req");
            else begin
               a = exp_rd.pop_front();
               chk("rd_addr", ip2bus_mst_addr, a);
            end
            if (slv_rdata.size() != 0) rd = slv_rdata.pop_front();
         end else begin
            if (exp_wr.size() == 0) fail_now("unexpected_wr_req");
            else begin
               w = exp_wr.pop_front();
               chk("wr_addr", ip2bus_mst_addr, w.addr);
               chk("wr_data", ip2bus_mstwr_d, w.data);
            end
         end
         if (slv_silent) continue;
         @(posedge clk);
         #1;
         bus2ip_mst_cmdack = 1'b1;
         repeat (slv_lat) begin
            @(posedge clk);
            #1;
            bus2ip_mst_cmdack = 1'b0;
         end
         bus2ip_mst_cmplt       = 1'b1;
         bus2ip_mst_error       = slv_err_next;
         bus2ip_mstrd_src_rdy_n = !is_rd;
         bus2ip_mstrd_d         = is_rd ? rd : 32'h0;
         slv_err_next           = 1'b0;
         @(posedge clk);
         #1;
         bus2ip_mst_cmdack      = 1'b0;
         bus2ip_mst_cmplt       = 1'b0;
         bus2ip_mst_error       = 1'b0;
         bus2ip_mstrd_src_rdy_n = 1'b1;
         bus2ip_mstrd_d         = '0;
      end
   end

   // Response consumer: ready high except for a programmed stall
   initial begin : ready_drv
      resp_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (resp_valid && resp_seen == stall_at && stall_left > 0) begin
            resp_ready = 1'b0;
            stall_left--;
         end else begin
            resp_ready = 1'b1;
         end
      end
   end

   // Response monitor: pops the expected read data on each accepted response
   initial begin : resp_mon
      logic [31:0] e;
      forever begin
         @(negedge clk);
         if (resp_valid && !resp_ready)
            chk("rd_req_during_stall", 32'(ip2bus_mstrd_req), 32'h0);
         if (resp_valid && resp_ready) begin
            resp_seen++;
            if (exp_resp.size() == 0) fail_now("unexpected_resp");
            else begin
               e = exp_resp.pop_front();
               chk("resp_data", resp_data, e);
            end
         end
      end
   end

   task automatic wait_idle(input string nm);
      int quiet = 0;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         if (fifo_q.size() == 0 && !fifo_valid && !busy && !seen) quiet++;
         else quiet = 0;
         if (quiet >= 4) return;
      end
      fail_now({nm, "_idle_timeout"});
   endtask

   task automatic chk_status(input string nm, input logic err, input logic [2:0] code,
                             input logic [7:0] cmds, input logic [7:0] drops);
      chk({nm, "_cmd_error"},  32'(cmd_error),  32'(err));
      chk({nm, "_error_code"}, 32'(error_code), 32'(code));
      chk({nm, "_cmd_count"},  32'(cmd_count),  32'(cmds));
      chk({nm, "_drop_count"}, 32'(drop_count), 32'(drops));
      chk({nm, "_wr_left"},    32'(exp_wr.size()),   32'h0);
      chk({nm, "_rd_left"},    32'(exp_rd.size()),   32'h0);
      chk({nm, "_resp_left"},  32'(exp_resp.size()), 32'h0);
   endtask

   task automatic clear_err();
      @(posedge clk);
      #1;
      err_clr = 1'b1;
      @(posedge clk);
      #1;
      err_clr = 1'b0;
      @(negedge clk);
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin : main
      wr_t w;
      reset   = 1'b1;
      err_clr = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("rst_fifo_rd_en",  32'(fifo_rd_en),       32'h0);
      chk("rst_rd_req",      32'(ip2bus_mstrd_req), 32'h0);
      chk("rst_wr_req",      32'(ip2bus_mstwr_req), 32'h0);
      chk("rst_addr",        ip2bus_mst_addr,       32'h0);
      chk("rst_be",          32'(ip2bus_mst_be),    32'hF);
      chk("rst_wr_d",        ip2bus_mstwr_d,        32'h0);
      chk("rst_resp_valid",  32'(resp_valid),       32'h0);
      chk("rst_resp_data",   resp_data,             32'h0);
      chk("rst_busy",        32'(busy),             32'h0);
      chk_status("rst", 1'b0, 3'd0, 8'd0, 8'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // two-beat write, immediate ack+cmplt
      slv_lat = 0;
      w.addr = 32'h6000_4000; w.data = 32'hA; exp_wr.push_back(w);
      w.addr = 32'h6000_4004; w.data = 32'hB; exp_wr.push_back(w);
      push(32'h0); push(32'h1000_0002); push(32'h6000_4000); push(32'hA); push(32'hB);
      wait_idle("wr2");
      chk_status("wr2", 1'b0, 3'd0, 8'd1, 8'd0);

      // three-beat read, ack then cmplt two cycles later, stall on beat 2
      slv_lat = 2;
      exp_rd.push_back(32'h6000_0080); exp_rd.push_back(32'h6000_0084); exp_rd.push_back(32'h6000_0088);
      slv_rdata.push_back(32'h1); slv_rdata.push_back(32'h2); slv_rdata.push_back(32'h3);
      exp_resp.push_back(32'h1); exp_resp.push_back(32'h2); exp_resp.push_back(32'h3);
      stall_at   = resp_seen + 1;
      stall_left = 5;
      push(32'h0); push(32'h2000_0003); push(32'h6000_0080);
      wait_idle("rd3");
      chk_status("rd3", 1'b0, 3'd0, 8'd2, 8'd0);
      slv_lat = 0;

      // leading garbage is dropped
      w.addr = 32'h6000_7044; w.data = 32'h1; exp_wr.push_back(w);
      push(32'h5); push(32'h7); push(32'h0); push(32'h1000_0001); push(32'h6000_7044); push(32'h1);
      wait_idle("drop");
      chk_status("drop", 1'b0, 3'd0, 8'd3, 8'd2);

      // address wraps past the top of the space
      w.addr = 32'hFFFF_FFFC; w.data = 32'h11; exp_wr.push_back(w);
      w.addr = 32'h0000_0000; w.data = 32'h22; exp_wr.push_back(w);
      push(32'h0); push(32'h1000_0002); push(32'hFFFF_FFFC); push(32'h11); push(32'h22);
      wait_idle("wrap");
      chk_status("wrap", 1'b0, 3'd0, 8'd4, 8'd2);

      // N==0 then bad opcode: first error wins, then clear
      push(32'h0); push(32'h2000_0000);
      wait_idle("n0");
      chk_status("n0", 1'b1, 3'd2, 8'd4, 8'd2);
      push(32'h0); push(32'h7000_0001);
      wait_idle("badop");
      chk_status("badop", 1'b1, 3'd2, 8'd4, 8'd2);
      clear_err();
      chk_status("clr1", 1'b0, 3'd0, 8'd4, 8'd2);

      // N above the maximum
      push(32'h0); push(32'h1000_0011);
      wait_idle("n17");
      chk_status("n17", 1'b1, 3'd2, 8'd4, 8'd2);
      clear_err();

      // bus error on first beat abandons the second, whose word is dropped
      slv_err_next = 1'b1;
      w.addr = 32'h6000_0200; w.data = 32'hC; exp_wr.push_back(w);
      push(32'h0); push(32'h1000_0002); push(32'h6000_0200); push(32'hC); push(32'hD);
      wait_idle("buserr");
      chk_status("buserr", 1'b1, 3'd3, 8'd4, 8'd3);
      clear_err();

      // no completion: request held for exactly the timeout, then error 4
      slv_silent = 1'b1;
      w.addr = 32'h6000_1000; w.data = 32'h55; exp_wr.push_back(w);
      push(32'h0); push(32'h1000_0001); push(32'h6000_1000); push(32'h55);
      wait_idle("tmo");
      chk("tmo_req_cycles", 32'(hi_cnt), 32'd16);
      chk_status("tmo", 1'b1, 3'd4, 8'd4, 8'd3);
      slv_silent = 1'b0;
      w.addr = 32'h6000_0010; w.data = 32'h77; exp_wr.push_back(w);
      push(32'h0); push(32'h1000_0001); push(32'h6000_0010); push(32'h77);
      wait_idle("after_tmo");
      chk_status("after_tmo", 1'b1, 3'd4, 8'd5, 8'd3);
      clear_err();

      // read-modify-write
`ifdef RMW_OP_EN
      exp_rd.push_back(32'h6000_4028);
      slv_rdata.push_back(32'hABCD_EFFF);
      w.addr = 32'h6000_4028; w.data = 32'hABCD_12FF; exp_wr.push_back(w);
      push(32'h0); push(32'h3000_0001); push(32'h6000_4028); push(32'h0000_FF00); push(32'h0000_1200);
      wait_idle("rmw");
      chk_status("rmw", 1'b0, 3'd0, 8'd6, 8'd3);
`else
      push(32'h0); push(32'h3000_0001); push(32'h6000_4028); push(32'h0000_FF00); push(32'h0000_1200);
      wait_idle("rmw");
      chk_status("rmw", 1'b1, 3'd1, 8'd5, 8'd6);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ipic_cmd_engine.md
Name: ipic_cmd_engine

Overview:
- Parametrised successor to the FIFO-driven IPIC register writer in the ath9k middleware.
- Parses framed command packets from the TX-side FIFO and issues single-beat IPIC master transactions to the ath9k register space.
- Supports multi-beat writes, reads with a response stream, an optional read-modify-write, a per-transaction timeout and sticky error status.

Parameters:
- C_DATA_WIDTH, 32, FIFO word, IPIC data and response width (must be 32).
- C_ADDR_WIDTH, 32, IPIC address width.
- C_MAX_BEATS, 16, maximum beat count N per command.
- C_CNT_WIDTH, 8, width of the N field and the status counters.
- C_ADDR_STRIDE, 4, byte increment between beats.
- C_TIMEOUT_CYCLES, 1024, cycles allowed from req assertion to cmplt.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- fifo_empty  in  1  command FIFO empty
- fifo_rd_en  out  1  FIFO pop; one-cycle read latency
- fifo_dread  in  C_DATA_WIDTH  FIFO data
- fifo_valid  in  1  fifo_dread valid
- ip2bus_mstrd_req  out  1  IPIC read request
- ip2bus_mstwr_req  out  1  IPIC write request
- ip2bus_mst_addr  out  C_ADDR_WIDTH  transaction address
- ip2bus_mst_be  out  C_DATA_WIDTH/8  byte enables (all ones)
- ip2bus_mstwr_d  out  C_DATA_WIDTH  write data
- bus2ip_mst_cmdack  in  1  command accepted
- bus2ip_mst_cmplt  in  1  transaction complete
- bus2ip_mst_error  in  1  bus error, sampled with cmplt
- bus2ip_mstrd_d  in  C_DATA_WIDTH  read data
- bus2ip_mstrd_src_rdy_n  in  1  read data valid, active-low
- resp_valid  out  1  read result available
- resp_data  out  C_DATA_WIDTH  read result
- resp_ready  in  1  consumer accepts resp_data
- err_clr  in  1  clears cmd_error and error_code
- busy  out  1  not in SYNC
- cmd_error  out  1  sticky error flag
- error_code  out  3  1 bad opcode, 2 bad N, 3 bus error, 4 timeout
- cmd_count  out  C_CNT_WIDTH  commands completed, wraps
- drop_count  out  C_CNT_WIDTH  non-zero words discarded in SYNC, saturates

Behaviour:
- Reset: all outputs 0, except ip2bus_mst_be = all ones; state SYNC.
- FIFO read protocol: fifo_rd_en is a single-cycle pulse, issued only when !fifo_empty. The next word is consumed on the cycle fifo_valid is high. Only one pop is outstanding at a time.
- Packet format:
  - word0: magic 0x00000000.
  - word1: header; [31:28] opcode, [C_CNT_WIDTH-1:0] N.
  - word2: base address.
  - Payload: opcode 1 WRITE carries N data words; opcode 2 READ carries none; opcode 3 RMW carries a mask word then a value word.
- SYNC: pop words; 0 -> HDR; any non-zero word -> increment drop_count and stay in SYNC.
- HDR: decode the header.
  - Opcode not in {1,2,3}, or 3 with RMW_OP_EN undefined -> error 1.
  - N==0 or N>C_MAX_BEATS -> error 2.
  - RMW ignores N and always performs 1 beat.
- ADDR: latch the address into the beat address register; beat index i=0.
- WRITE loop: pop data word -> ISSUE_WR (mstwr_req=1, addr=base+i*C_ADDR_STRIDE) -> WAIT_ACK -> WAIT_CMPLT.
  - On cmplt, drop the req in the same cycle.
  - i++; repeat until i==N.
- READ loop: ISSUE_RD (mstrd_req=1) -> WAIT_ACK.
  - Capture bus2ip_mstrd_d when src_rdy_n==0.
  - On cmplt -> RESP: resp_valid=1 until resp_ready; the engine stalls, without timeout, while !resp_ready.
  - i++; repeat.
- Request hold: req stays high from issue until cmplt. It never deasserts on cmdack alone; cmdack and cmplt in the same cycle are legal.
- Timeout: a counter runs from req assertion. Reaching C_TIMEOUT_CYCLES without cmplt -> drop the req, error 4.
- Bus errors: cmplt with bus2ip_mst_error -> error 3; the remaining beats are abandoned.
- Error handling:
  - Set cmd_error and error_code; return to SYNC.
  - Unconsumed payload words are discarded by SYNC and counted in drop_count.
  - First error wins; later errors do not overwrite error_code until err_clr.
  - err_clr in the same cycle as a new error: the new error is retained.
- Completion: cmd_count increments once per command finished without error, wrapping mod 2^C_CNT_WIDTH.
- Address arithmetic is modulo 2^C_ADDR_WIDTH; wrap is permitted.
- reset mid-transaction: requests drop in the next cycle; any in-flight IPIC completion is ignored.

Optional Feature:
- RMW_OP_EN defined: opcode 3 is supported.
  - Sequence: pop mask M, pop value V, single read of the address, then write (old & ~M) | (V & M) to the same address.
  - No response word is produced.
  - An error on the read skips the write.
- RMW_OP_EN undefined: opcode 3 -> error 1; no RMW datapath is synthesised.

Test Plan:
- FIFO {0, 0x10000002, 0x60004000, 0xA, 0xB}, immediate cmdack and cmplt -> writes 0xA@0x60004000 then 0xB@0x60004004; cmd_count=1; cmd_error=0.
- FIFO {0, 0x20000003, 0x60000080}, read data 1,2,3, resp_ready low for 5 cycles on beat 2 -> resp_data 1,2,3 in order; mstrd_req does not assert while stalled.
- FIFO {5, 7, 0, 0x10000001, 0x60007044, 0x1} -> drop_count=2; one write of 0x1@0x60007044.
- Header 0x20000000, then header 0x70000001 -> error_code=2, then error_code stays 2 (first wins); err_clr -> cmd_error=0.
- Write with cmplt never returned, C_TIMEOUT_CYCLES=16 -> mstwr_req falls after 16 cycles; error_code=4; next packet processes normally.
- With RMW_OP_EN: {0, 0x30000001, 0x60004028, 0x0000FF00, 0x00001200}, old value 0xABCDEFFF -> writes 0xABCD12FF; without RMW_OP_EN -> error_code=1, no IPIC request.
